// File: rtl/mole_spawn_timer.sv
// Difficulty-selected mole spawn pulse generator with run/pause, restart and a saturating spawn counter.
// Optional interval jitter is compiled in with `define MOLE_SPAWN_JITTER_EN.
module mole_spawn_timer #(
  parameter int CNT_W      = 29,
  parameter int INTERVAL_0 = 200000000,
  parameter int INTERVAL_1 = 120000000,
  parameter int INTERVAL_2 = 80000000,
  parameter int INTERVAL_3 = 50000000,
  parameter int SPAWN_W    = 16
) (
  input  logic               CLK100MHZ,
  input  logic               rst,
  input  logic               run,
  input  logic               restart,
  input  logic [1:0]         difficulty,
  output logic               enable,
  output logic [SPAWN_W-1:0] spawn_count,
  output logic [1:0]         active_level
);

  if (INTERVAL_0 < 2 || INTERVAL_1 < 2 || INTERVAL_2 < 2 || INTERVAL_3 < 2) begin : g_bad_interval
    $error("mole_spawn_timer: every INTERVAL_n must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   term_q, term_d;
  logic [SPAWN_W-1:0] spawn_q, spawn_d;
  logic [1:0]         level_q, level_d;
  logic               enable_q, enable_d;
  logic [CNT_W-1:0]   jitter;
  logic [CNT_W-1:0]   new_term;

  function automatic logic [CNT_W-1:0] interval_term(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return CNT_W'(INTERVAL_0 - 1);
      2'd1:    return CNT_W'(INTERVAL_1 - 1);
      2'd2:    return CNT_W'(INTERVAL_2 - 1);
      default: return CNT_W'(INTERVAL_3 - 1);
    endcase
  endfunction

  function automatic logic [SPAWN_W-1:0] sat_inc(input logic [SPAWN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef MOLE_SPAWN_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst)          lfsr_q <= 16'hACE1;
    else if (restart) lfsr_q <= 16'hACE1;
    else              lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign jitter = CNT_W'({lfsr_q, 8'h00});
`else
  assign jitter = '0;
`endif

  assign new_term = interval_term(difficulty) - jitter;

  // FIRE doubles as counter value 0 of the next interval, so the pulse period stays at INTERVAL.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    spawn_d  = spawn_q;
    level_d  = level_q;
    enable_d = 1'b0;
    if (restart) begin
      state_d = IDLE;
      cnt_d   = '0;
      spawn_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            level_d = difficulty;
            term_d  = new_term;
            cnt_d   = '0;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (run) begin
            if (cnt_q == term_q) begin
              state_d  = FIRE;
              enable_d = 1'b1;
              spawn_d  = sat_inc(spawn_q);
              level_d  = difficulty;
              term_d   = new_term;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        FIRE: begin
          state_d = COUNT;
          if (run) cnt_d = cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      term_q   <= '0;
      spawn_q  <= '0;
      level_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      term_q   <= term_d;
      spawn_q  <= spawn_d;
      level_q  <= level_d;
      enable_q <= enable_d;
    end
  end

  assign enable       = enable_q;
  assign spawn_count  = spawn_q;
  assign active_level = level_q;

endmodule

// File: tb/tb_mole_spawn_timer.sv
// Bench for mole_spawn_timer: directed steps plus random run/restart/difficulty traffic against a countdown model.
module tb_mole_spawn_timer;
  localparam int I0 = 10;
  localparam int I1 = 8;
  localparam int I2 = 6;
  localparam int I3 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        restart;
  logic [1:0]  difficulty;
  logic        en_a, en_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [1:0]  lvl_a, lvl_b;

  always #5 clk = ~clk;

  mole_spawn_timer #(.CNT_W(8), .INTERVAL_0(I0), .INTERVAL_1(I1), .INTERVAL_2(I2),
                     .INTERVAL_3(I3), .SPAWN_W(16)) u_dut (
    .CLK100MHZ(clk), .rst(rst), .run(run), .restart(restart), .difficulty(difficulty),
    .enable(en_a), .spawn_count(cnt_a), .active_level(lvl_a));

  mole_spawn_timer #(.CNT_W(8), .INTERVAL_0(I0), .INTERVAL_1(I1), .INTERVAL_2(I2),
                     .INTERVAL_3(I3), .SPAWN_W(2)) u_dut_sat (
    .CLK100MHZ(clk), .rst(rst), .run(run), .restart(restart), .difficulty(difficulty),
    .enable(en_b), .spawn_count(cnt_b), .active_level(lvl_b));

  int vectors = 0;
  int miscompares = 0;
  int intervals [4] = '{I0, I1, I2, I3};

  // Model: after the starting run edge, a pulse lands on the INTERVAL-th following edge with run=1.
  bit m_running;
  int m_left;
  int m_level;
  int m_cnt;
  int m_cnt_sat;
  bit m_en;

  function automatic void model_reset();
    m_running = 1'b0;
    m_left    = 0;
    m_level   = 0;
    m_cnt     = 0;
    m_cnt_sat = 0;
    m_en      = 1'b0;
  endfunction

  function automatic void model_edge();
    m_en = 1'b0;
    if (rst) begin
      model_reset();
    end else if (restart) begin
      m_running = 1'b0;
      m_cnt     = 0;
      m_cnt_sat = 0;
    end else if (!m_running) begin
      if (run) begin
        m_running = 1'b1;
        m_level   = int'(difficulty);
        m_left    = intervals[difficulty];
      end
    end else if (run) begin
      m_left--;
      if (m_left == 0) begin
        m_en      = 1'b1;
        m_cnt     = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_cnt_sat = (m_cnt_sat == 3) ? 3 : m_cnt_sat + 1;
        m_level   = int'(difficulty);
        m_left    = intervals[difficulty];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string phase);
    chk({phase, ".enable"},          32'(en_a),  32'(m_en));
    chk({phase, ".enable_w2"},       32'(en_b),  32'(m_en));
    chk({phase, ".spawn_count"},     32'(cnt_a), 32'(m_cnt));
    chk({phase, ".spawn_count_w2"},  32'(cnt_b), 32'(m_cnt_sat));
    chk({phase, ".active_level"},    32'(lvl_a), 32'(m_level));
    chk({phase, ".active_level_w2"}, 32'(lvl_b), 32'(m_level));
  endtask

  task automatic cyc(input string phase);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(phase);
  endtask

  task automatic drive(input string phase, input bit r, input bit rs, input logic [1:0] d, input int n);
    run        = r;
    restart    = rs;
    difficulty = d;
    repeat (n) cyc(phase);
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    run        = 1'b0;
    restart    = 1'b0;
    difficulty = 2'd0;
    model_reset();
    cyc("reset");
    cyc("reset");
    rst = 1'b0;

    drive("idle", 1'b0, 1'b0, 2'd2, 3);

    // Pulses on edges 10, 20, 30 after run is first sampled.
    drive("basic", 1'b1, 1'b0, 2'd0, 32);
    chk("basic.three_pulses", 32'(cnt_a), 32'd3);

    drive("level_chg", 1'b1, 1'b1, 2'd3, 1);
    drive("level_chg", 1'b1, 1'b0, 2'd3, 3);
    drive("level_chg", 1'b1, 1'b0, 2'd1, 20);

    drive("pause", 1'b1, 1'b1, 2'd2, 1);
    drive("pause", 1'b1, 1'b0, 2'd2, 3);
    drive("pause", 1'b0, 1'b0, 2'd2, 5);
    drive("pause", 1'b1, 1'b0, 2'd2, 14);

    drive("restart_fire", 1'b1, 1'b1, 2'd0, 1);
    drive("restart_fire", 1'b1, 1'b0, 2'd0, 1);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_running && m_left == 1) begin
        found = 1'b1;
        break;
      end
      cyc("restart_fire");
    end
    chk("restart_fire.window_reached", 32'(found), 32'd1);
    drive("restart_fire", 1'b1, 1'b1, 2'd0, 1);
    chk("restart_fire.no_pulse", 32'(en_a), 32'd0);
    drive("restart_fire", 1'b1, 1'b0, 2'd0, 15);

    drive("async_rst", 1'b1, 1'b0, 2'd3, 10);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #1;
    rst = 1'b0;

    // Five pulses at difficulty 3: the 2-bit counter reads 1, 2, 3, 3, 3.
    drive("saturate", 1'b1, 1'b0, 2'd3, 22);
    chk("saturate.w2_held", 32'(cnt_b), 32'd3);

    for (int k = 0; k < 400; k++) begin
      run        = ($urandom % 8) != 0;
      restart    = ($urandom % 40) == 0;
      difficulty = 2'($urandom % 4);
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
